// File: rtl/tx_word_uart_if.sv
// Controller-facing bundle for tx_word_uart: word strobe/ready handshake, serial line, debug state.
// LOGIP_GROUP_MASK_EN adds the per-byte disable mask grp_dis_i.
interface tx_word_uart_if #(
  parameter int TX_WIDTH = 32
);
  // Handshake: a word transfers on a rising clk_i edge where tx_stb_i && tx_rdy_o;
  // tx_i (and grp_dis_i) are sampled only on that edge and may change freely otherwise.
  logic                tx_stb_i;
  logic [TX_WIDTH-1:0] tx_i;
  logic                tx_rdy_o;
  logic                uart_tx_o;
  logic [1:0]          state_o;
`ifdef LOGIP_GROUP_MASK_EN
  logic [TX_WIDTH/8-1:0] grp_dis_i;

  modport master (output tx_stb_i, tx_i, grp_dis_i, input tx_rdy_o, uart_tx_o, state_o);
  modport slave  (input tx_stb_i, tx_i, grp_dis_i, output tx_rdy_o, uart_tx_o, state_o);
`else
  modport master (output tx_stb_i, tx_i, input tx_rdy_o, uart_tx_o, state_o);
  modport slave  (input tx_stb_i, tx_i, output tx_rdy_o, uart_tx_o, state_o);
`endif
endinterface

// File: rtl/tx_word_uart.sv
// Sends each accepted TX_WIDTH-bit word as TX_WIDTH/8 back-to-back 8N1 frames, LSB byte first.
// Optional LOGIP_GROUP_MASK_EN: bytes flagged in grp_dis_i are skipped entirely.
module tx_word_uart #(
  parameter int TX_WIDTH     = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk_i,
  input  logic         rst_i,
  tx_word_uart_if.slave bus
);
  localparam int NB     = TX_WIDTH / 8;
  localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  if (TX_WIDTH % 8 != 0 || TX_WIDTH < 8 || CLKS_PER_BIT < 2) begin : g_param_err
    $error("tx_word_uart: TX_WIDTH must be a multiple of 8 (>= 8) and CLKS_PER_BIT >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic [NB-1:0][7:0]    word_q, word_d;
  logic [NB-1:0]         en_q, en_d;
  logic                  rdy_q, rdy_d;
  logic                  line_q, line_d;
  logic                  accept;
  logic                  bit_end;
  logic [NB-1:0]         en_in;
  logic [BYTE_W:0]       first_en;
  logic [BYTE_W:0]       next_en;

  // Lowest enabled byte index >= from; MSB of the result flags that one exists.
  function automatic logic [BYTE_W:0] find_en(input logic [NB-1:0] mask, input int from);
    logic [BYTE_W:0] r;
    r = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) r = {1'b1, BYTE_W'(i)};
    end
    return r;
  endfunction

`ifdef LOGIP_GROUP_MASK_EN
  assign en_in = ~bus.grp_dis_i;
`else
  assign en_in = '1;
`endif

  assign accept   = (state_q == IDLE) && rdy_q && bus.tx_stb_i;
  assign bit_end  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign first_en = find_en(en_in, 0);
  assign next_en  = find_en(en_q, int'(byte_q) + 1);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d = bus.tx_i;
          en_d   = en_in;
          baud_d = '0;
          bit_d  = '0;
          // With every byte disabled the word is consumed without leaving IDLE.
          if (first_en[BYTE_W]) begin
            state_d = START;
            byte_d  = first_en[BYTE_W-1:0];
          end
        end
      end
      START: begin
        baud_d = baud_q + BAUD_W'(1);
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + BAUD_W'(1);
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        baud_d = baud_q + BAUD_W'(1);
        if (bit_end) begin
          baud_d = '0;
          bit_d  = '0;
          if (next_en[BYTE_W]) begin
            state_d = START;
            byte_d  = next_en[BYTE_W-1:0];
          end else begin
            state_d = IDLE;
            byte_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next state so the flops present them one cycle after the decision.
    rdy_d = (state_d == IDLE) && !accept;
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = word_d[byte_d][bit_d];
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      en_q    <= '0;
      rdy_q   <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
      line_q  <= line_d;
    end
  end

  assign bus.tx_rdy_o  = rdy_q;
  assign bus.uart_tx_o = line_q;
  assign bus.state_o   = state_q;
endmodule

// File: doc/tx_word_uart.md
Name: tx_word_uart

Overview:
Downstream transmit stage of the capture controller. Accepts one TX_WIDTH-bit readback word per strobe and sends it as TX_WIDTH/8 UART frames (8N1), least-significant byte first, to the host. Signals readiness back to the controller, which waits on it between words.

Parameters:
TX_WIDTH, 32, bits per accepted word; must be a multiple of 8, at least 8.
CLKS_PER_BIT, 868, clk_i cycles per UART bit (100 MHz / 115200); must be >= 2.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
tx_stb_i  input  1  word strobe from controller; qualified by tx_rdy_o
tx_i  input  TX_WIDTH  word to transmit; sampled when the strobe is accepted
tx_rdy_o  output  1  high when idle and able to accept a word
uart_tx_o  output  1  serial line; idle high

Behaviour:
- Decided: one clock, clk_i; rst_i is asynchronous and active-high.
- Reset values: tx_rdy_o=1, uart_tx_o=1, all counters 0, state IDLE.
- Reset asserted mid-frame: uart_tx_o=1 and tx_rdy_o=1 immediately, without waiting for a clock edge. The frame in progress is dropped. No residue remains after reset is released.
- Both outputs are registered, with no combinational path from input to output.
- Accept: tx_stb_i=1 while tx_rdy_o=1 latches tx_i into the shift register.
  - Next cycle: tx_rdy_o=0 and uart_tx_o=0 (start bit).
  - Strobe while tx_rdy_o=0 is ignored, and tx_i is not resampled.
- States:
  - IDLE: waits for an accepted strobe, then goes to START.
  - START: holds the line 0 for CLKS_PER_BIT cycles, then goes to DATA.
  - DATA: sends 8 bits, LSB first, each for CLKS_PER_BIT cycles, then goes to STOP.
  - STOP: holds the line 1 for CLKS_PER_BIT cycles. Goes to START if bytes remain, else to IDLE.
- Byte order: byte 0 (tx_i[7:0]) first, byte TX_WIDTH/8-1 last. There is no idle gap between frames: the stop bit is followed directly by the next start bit.
- Counters:
  - Baud counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
  - Bit index: 3 bits.
  - Byte index: $clog2(TX_WIDTH/8) bits, minimum 1.
- Timing: tx_rdy_o returns to 1 in the cycle after the last stop bit's final cycle. Busy time per word is exactly 10*CLKS_PER_BIT*(TX_WIDTH/8) cycles.
- A strobe in the same cycle that tx_rdy_o rises is not accepted, because tx_rdy_o is still 0 at that edge. The earliest accept is the following cycle.
- Back-to-back words: a strobe held high continuously is re-accepted on the first cycle tx_rdy_o=1. This gives 1 idle-high cycle between words.
- Parameter violation (TX_WIDTH%8!=0 or CLKS_PER_BIT<2): elaboration-time $error.

Optional Feature:
Macro LOGIP_GROUP_MASK_EN.
- Defined:
  - Adds input grp_dis_i, width TX_WIDTH/8; bit n=1 disables byte n.
  - grp_dis_i is sampled together with tx_i on accept.
  - Disabled bytes are skipped entirely, with no frame sent.
  - Busy time becomes 10*CLKS_PER_BIT*(number of enabled bytes).
  - All bytes disabled: the word is accepted, uart_tx_o stays 1, and tx_rdy_o returns to 1 one cycle after it drops.
- Undefined: the port is absent and all bytes are always sent.

Test Plan:
- Single word: CLKS_PER_BIT=4, TX_WIDTH=32, tx_i=0xA5C30F81, one-cycle strobe.
  - Line decodes to 0x81, 0x0F, 0xC3, 0xA5 in order, with start=0 and stop=1 for each frame.
  - tx_rdy_o stays low for exactly 160 cycles, and uart_tx_o falls 1 cycle after the accept.
- Strobe while busy: second strobe with tx_i=0xFFFFFFFF during byte 1.
  - Ignored: only the first word appears, and tx_rdy_o timing is unchanged.
- Continuous strobe: tx_stb_i held high across two words (0x00000000, then 0x12345678).
  - Exactly 1 idle-high cycle between the two 160-cycle bursts.
  - Second word decodes as 0x78, 0x56, 0x34, 0x12.
- Async reset: assert rst_i mid-DATA of byte 2, between clock edges.
  - uart_tx_o=1 and tx_rdy_o=1 before the next clk_i edge.
  - A fresh word 0x000000FF after release transmits correctly.
- LOGIP_GROUP_MASK_EN:
  - grp_dis_i=4'b1010, tx_i=0x44332211: sends only 0x11, 0x33, with busy time 80 cycles.
  - grp_dis_i=4'b1111: tx_rdy_o is low for 1 cycle and the line never leaves 1.
